// File: rtl/csa_pkg.sv
// Shared types and helpers for the digit-serial carry-select subtractor.
package csa_pkg;

  localparam int SLICE_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slices needed to cover a full word.
  function automatic int num_slices(input int width, input int slice_w);
    return width / slice_w;
  endfunction

endpackage

// File: rtl/csa_slice.sv
// One carry-select cell: both carry-in candidates are summed up front and
// the incoming carry only drives the final mux.
module csa_slice #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               c,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W:0] sum0;
  logic [SLICE_W:0] sum1;

  assign sum0 = {1'b0, x} + {1'b0, y};
  assign sum1 = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, 1'b1};

  // Carry picks between the two precomputed candidates.
  always_comb begin
    s  = sum0[SLICE_W-1:0];
    co = sum0[SLICE_W];
    if (c) begin
      s  = sum1[SLICE_W-1:0];
      co = sum1[SLICE_W];
    end
  end

endmodule

// File: rtl/csa_serial_sub.sv
// Digit-serial subtractor: diff = a - b - bin, computed as a + ~b + ~bin,
// one carry-select slice per clock, LSB slice first.
//
// state | meaning
// IDLE  | ready for operands
// RUN   | processing slice cnt
// DONE  | result held until consumer takes it
module csa_serial_sub
  import csa_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = num_slices(WIDTH, SLICE_W);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST  = CW'(N - 1);
  localparam logic [WIDTH-1:0] SMASK = WIDTH'({SLICE_W{1'b1}});

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("csa_serial_sub: WIDTH must be a nonzero multiple of SLICE_W");
  end

  state_t state, state_nxt;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   nb_q;
  logic [WIDTH-1:0]   diff_q;
  logic [CW-1:0]      cnt;
  logic               c;
  logic               bout_q;
  logic               ovf_q;
  logic               in_ready_q;
  logic               accept;
  logic               last;
  int                 base;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   nb_sh;
  logic [SLICE_W-1:0] x;
  logic [SLICE_W-1:0] y;
  logic [SLICE_W-1:0] s;
  logic               co;

  assign accept = in_valid && in_ready_q;
  assign last   = (state == RUN) && (cnt == LAST);

  // Slice selection: shift the operand registers down to the active slice.
  assign base  = int'(cnt) * SLICE_W;
  assign a_sh  = a_q >> base;
  assign nb_sh = nb_q >> base;
  assign x     = a_sh[SLICE_W-1:0];
  assign y     = nb_sh[SLICE_W-1:0];

  csa_slice #(.SLICE_W(SLICE_W)) u_slice (
    .x  (x),
    .y  (y),
    .c  (c),
    .s  (s),
    .co (co)
  );

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // State register; in_ready is a flop so it stays low through reset and
  // rises on the first clock after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt == IDLE);
    end
  end

  // Operand capture, slice sequencing and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      nb_q   <= '0;
      diff_q <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      nb_q   <= ~b;
      diff_q <= '0;
      cnt    <= '0;
      c      <= ~bin;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == RUN) begin
      diff_q <= (diff_q & ~(SMASK << base)) | (WIDTH'(s) << base);
      c      <= co;
      cnt    <= cnt + 1'b1;
      if (last) begin
        bout_q <= ~co;
        // a and b differ in sign exactly when a and ~b agree.
        ovf_q  <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) && (s[SLICE_W-1] != a_q[WIDTH-1]);
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_serial_sub.sv
// Directed bench for csa_serial_sub at default parameters.
module tb_csa_serial_sub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  csa_serial_sub #(.WIDTH(16), .SLICE_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for in_ready (bounded), then present operands for exactly one edge.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb_v; bin = ~tbin;
  endtask

  // Count cycles from the accept edge until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ov_drop", {31'd0, out_valid}, 32'd0);
    chk("rdy_back", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tbin, input logic [15:0] ed, input logic eb, input logic eo);
    int lat;
    start_op(ta, tb_v, tbin);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, 32'd4);
    chk({tag, "_diff"}, {16'd0, diff}, {16'd0, ed});
    chk({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    take_result();
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", {31'd0, in_ready}, 32'd0);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", {16'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_rdy", {31'd0, in_ready}, 32'd1);

    do_op("t1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    do_op("t2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    do_op("t3", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    do_op("t4", 16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0);
    do_op("t5", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    // Backpressure with stray in_valid pulses while DONE.
    start_op(16'h0010, 16'h0001, 1'b0);
    wait_valid(lat);
    chk("bp_lat", lat, 32'd4);
    for (int i = 0; i < 3; i++) begin
      a = 16'hFFFF; b = 16'h0000; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_ov", {31'd0, out_valid}, 32'd1);
      chk("bp_rdy", {31'd0, in_ready}, 32'd0);
      chk("bp_diff", {16'd0, diff}, 32'h000F);
    end
    in_valid = 1'b0;
    take_result();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("bp_nocap", seen, 32'd0);
    chk("bp_idle", {31'd0, in_ready}, 32'd1);

    // Reset during the second slice of an operation.
    start_op(16'h5555, 16'h1111, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mr_ov", {31'd0, out_valid}, 32'd0);
    chk("mr_diff", {16'd0, diff}, 32'd0);
    chk("mr_bout", {31'd0, bout}, 32'd0);
    chk("mr_rdy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mr_rel_rdy", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mr_noresult", seen, 32'd0);

    do_op("t6", 16'h00FF, 16'h0100, 1'b0, 16'hFFFF, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
